// File: rtl/npu_reg_pkg.sv
// Shared types and constants for the NPU register-port bus master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: command op encodings, FSM states, the queued command record,
// NPU register address map and STATUS bit positions.
package npu_reg_pkg;

    typedef enum logic [1:0] {
        OP_WRITE    = 2'd0,
        OP_READ     = 2'd1,
        OP_POLL     = 2'd2,
        OP_WAIT_INT = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_RD_CAP,
        ST_RSP,
        ST_GAP,
        ST_INT_WAIT
    } state_e;

    // One queued command: 2-bit op, 8-bit address, 32-bit data (42 bits).
    typedef struct packed {
        logic [1:0]  op;
        logic [7:0]  adr;
        logic [31:0] dat;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    // NPU register map (byte addresses).
    localparam logic [7:0] ADR_CTRL   = 8'h00;
    localparam logic [7:0] ADR_STATUS = 8'h04;
    localparam logic [7:0] ADR_OP     = 8'h08;
    localparam logic [7:0] ADR_MSEL   = 8'h0C;
    localparam logic [7:0] ADR_RMAX   = 8'hC0;
    localparam logic [7:0] ADR_RMIN   = 8'hC4;

    // STATUS bit positions; CTRL bit 1 starts a job.
    localparam int STAT_FINISH = 0;
    localparam int STAT_RUN    = 1;
    localparam int CTRL_START  = 1;

endpackage

// File: rtl/npu_reg_master_if.sv
// Bundle of command, response and NPU register-bus signals for npu_reg_master.
// Latency: n/a (wires only).
// Backpressure: CMD_VALID/CMD_READY on commands, RSP_VALID/RSP_READY on results.
//
// Modports: master = the bus initiator (npu_reg_master),
//           slave  = the environment (command source, result sink, NPU responder).
interface npu_reg_master_if;

    // Command stream
    logic        CMD_VALID;
    logic        CMD_READY;
    logic [1:0]  CMD_OP;
    logic [7:0]  CMD_ADR;
    logic [31:0] CMD_DATA;
    // Result stream
    logic        RSP_VALID;
    logic        RSP_READY;
    logic [31:0] RSP_DATA;
    logic        RSP_ERR;
    // NPU register bus
    logic [7:0]  ADR;
    logic        WR;
    logic [31:0] WDATA;
    logic        RD;
    logic [31:0] RDATA;
    logic        INT;
    // Status
    logic        BUSY;

    modport master (
        input  CMD_VALID, CMD_OP, CMD_ADR, CMD_DATA, RSP_READY, RDATA, INT,
        output CMD_READY, RSP_VALID, RSP_DATA, RSP_ERR, ADR, WR, WDATA, RD, BUSY
    );

    modport slave (
        output CMD_VALID, CMD_OP, CMD_ADR, CMD_DATA, RSP_READY, RDATA, INT,
        input  CMD_READY, RSP_VALID, RSP_DATA, RSP_ERR, ADR, WR, WDATA, RD, BUSY
    );

endinterface

// File: rtl/npu_reg_cmd_fifo.sv
// Synchronous command FIFO, DEPTH entries of WIDTH bits, first-word fall-through.
// Latency: a pushed entry is visible on pop_dat the cycle after the push.
// Backpressure: full blocks push unless a pop happens in the same cycle.
//
// Ports: clk/rst (async active-high), push/push_dat/full, pop/pop_dat/empty.
module npu_reg_cmd_fifo #(
    parameter int WIDTH = 42,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/npu_reg_master.sv
// NPU register-port initiator: runs queued WRITE/READ/POLL/WAIT_INT commands.
// Latency: WR 2 cycles after accept; READ result 4 cycles after accept.
// Backpressure: CMD_READY low when the queue is full; FSM holds in RSP until RSP_READY.
//
// Ports: CLK, RESET (async active-high), bus (npu_reg_master_if.master):
//   CMD_* command in, RSP_* result out, ADR/WR/WDATA/RD/RDATA/INT to the NPU, BUSY.
// Optional: define NPU_REG_MASTER_TIMEOUT_EN to bound POLL/WAIT_INT by TIMEOUT
//   cycles and report expiry with RSP_ERR=1; otherwise they wait forever.
module npu_reg_master
    import npu_reg_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int POLL_GAP  = 4,
    parameter int TIMEOUT   = 65535
) (
    input  logic             CLK,
    input  logic             RESET,
    npu_reg_master_if.master bus
);

    localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(POLL_GAP - 1);

    // ------------------------------------------------------------------
    // Command queue
    // ------------------------------------------------------------------
    cmd_t             cmd_in;
    cmd_t             head;
    logic [CMD_W-1:0] head_raw;
    logic             fifo_full, fifo_empty, fifo_push, fifo_pop;

    assign cmd_in    = '{op: bus.CMD_OP, adr: bus.CMD_ADR, dat: bus.CMD_DATA};
    assign fifo_push = bus.CMD_VALID && !fifo_full;
    assign head      = cmd_t'(head_raw);

    npu_reg_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk      (CLK),
        .rst      (RESET),
        .push     (fifo_push),
        .push_dat (cmd_in),
        .full     (fifo_full),
        .pop      (fifo_pop),
        .pop_dat  (head_raw),
        .empty    (fifo_empty)
    );

    // ------------------------------------------------------------------
    // FSM state and registered outputs
    // ------------------------------------------------------------------
    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [4:0]         bit_q, bit_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [7:0]         adr_q, adr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               wr_q, wr_d;
    logic               rd_q, rd_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_data_q, rsp_data_d;
`ifdef NPU_REG_MASTER_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    logic [15:0]        tmo_q, tmo_d;
    logic [31:0]        last_q, last_d;
    logic               rsp_err_q, rsp_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        bit_d       = bit_q;
        gap_d       = gap_q;
        adr_d       = adr_q;
        wdata_d     = wdata_q;
        wr_d        = 1'b0;
        rd_d        = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        fifo_pop    = 1'b0;
`ifdef NPU_REG_MASTER_TIMEOUT_EN
        tmo_d       = tmo_q;
        last_d      = last_q;
        rsp_err_d   = rsp_err_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    op_d     = op_e'(head.op);
                    adr_d    = head.adr;
                    wdata_d  = head.dat;
                    bit_d    = head.dat[4:0];
                    unique case (op_e'(head.op))
                        OP_WRITE: begin
                            wr_d    = 1'b1;
                            state_d = ST_WRITE;
                        end
                        OP_READ, OP_POLL: begin
                            rd_d    = 1'b1;
                            state_d = ST_READ;
                        end
                        default: state_d = ST_INT_WAIT;
                    endcase
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            ST_READ:  state_d = ST_RD_CAP;
            ST_RD_CAP: begin
                // RDATA belongs to the RD issued two edges ago.
                if (op_q == OP_READ || bus.RDATA[bit_q]) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = bus.RDATA;
                    state_d     = ST_RSP;
                end else begin
                    gap_d   = GAP_LOAD;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    rd_d    = 1'b1;
                    state_d = ST_READ;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            ST_INT_WAIT: begin
                if (bus.INT) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    state_d     = ST_RSP;
                end
            end
            ST_RSP: begin
                if (bus.RSP_READY) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef NPU_REG_MASTER_TIMEOUT_EN
        // Any freshly posted response is a success unless expiry overrides below.
        if (state_d == ST_RSP && state_q != ST_RSP) rsp_err_d = 1'b0;
        if (state_q == ST_IDLE) begin
            tmo_d  = '0;
            last_d = '0;
        end
        if (state_q == ST_RD_CAP) last_d = bus.RDATA;
        if (op_q != OP_READ &&
            state_q inside {ST_READ, ST_RD_CAP, ST_GAP, ST_INT_WAIT}) begin
            tmo_d = tmo_q + 16'd1;
            // A success decided this same cycle already moved state_d to RSP and wins.
            if (tmo_q == TMO_LAST && state_d != ST_RSP) begin
                rd_d        = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
                rsp_data_d  = (op_q == OP_POLL) ? last_d : 32'd0;
                state_d     = ST_RSP;
            end
        end
`endif
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_WRITE;
            bit_q       <= '0;
            gap_q       <= '0;
            adr_q       <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
`ifdef NPU_REG_MASTER_TIMEOUT_EN
            tmo_q       <= '0;
            last_q      <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            bit_q       <= bit_d;
            gap_q       <= gap_d;
            adr_q       <= adr_d;
            wdata_q     <= wdata_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
`ifdef NPU_REG_MASTER_TIMEOUT_EN
            tmo_q       <= tmo_d;
            last_q      <= last_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.CMD_READY = !fifo_full;
    assign bus.ADR       = adr_q;
    assign bus.WR        = wr_q;
    assign bus.WDATA     = wdata_q;
    assign bus.RD        = rd_q;
    assign bus.RSP_VALID = rsp_valid_q;
    assign bus.RSP_DATA  = rsp_data_q;
    assign bus.BUSY      = (state_q != ST_IDLE) || !fifo_empty;
`ifdef NPU_REG_MASTER_TIMEOUT_EN
    assign bus.RSP_ERR   = rsp_err_q;
`else
    assign bus.RSP_ERR   = 1'b0;
`endif

endmodule
